dac_sample_scheduler: RTL and testbench

DAC_SAMPLE_SCHEDULER -- requirements
Module: dac_sample_scheduler

---
 rtl/dac_pkg.sv | 25 ++
 rtl/dac_sample_scheduler_tick.sv | 32 +++
 rtl/dac_sample_scheduler.sv | 128 ++++++++++++
 tb/tb_dac_sample_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC sample scheduler.
// Frame layout: control nibble followed by the sample, MSB first.
package dac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    FETCH1,
    CAP1,
    CAP2,
    LAUNCH,
    WAIT_SPI
  } state_t;

  localparam int DAC_DATA_W = 12;
  localparam int FRAME_W = 16;
  localparam logic [3:0] FRAME_CTRL = 4'b0000;

  function automatic logic [FRAME_W-1:0] make_frame(
    input logic [DAC_DATA_W-1:0] s
  );
    return {FRAME_CTRL, s};
  endfunction

endpackage

// File: rtl/dac_sample_scheduler_tick.sv
// Sample-period counter for the DAC scheduler.
// Emits a registered one-cycle tick every SAMPLE_DIV cycles while enabled.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 2500
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count while enabled; tick registered so the first one lands
  // SAMPLE_DIV cycles after enable is first seen high.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Dual-channel DAC sample scheduler: phase accumulators, LUT fetch
// sequencing and SPI frame launch with overrun detection.
module dac_sample_scheduler
  import dac_pkg::*;
#(
  parameter int SAMPLE_DIV = 2500,
  parameter int ACC_W      = 16,
  parameter int LUT_AW     = 8,
  parameter int DATA_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sel_wave,
  input  logic [ACC_W-1:0]  phase_inc1,
  input  logic [ACC_W-1:0]  phase_inc2,
  output logic [LUT_AW:0]   lut_addr,
  input  logic [DATA_W-1:0] lut_data,
  output logic              spi_start,
  output logic [15:0]       spi_word1,
  output logic [15:0]       spi_word2,
  input  logic              spi_busy,
  output logic              ready,
  output logic              overrun
);

  state_t state, state_nx;

  logic              tick;
  logic              fire;
  logic              spi_first;
  logic              bank;
  logic [ACC_W-1:0]  acc1, acc2;
  logic [DATA_W-1:0] sample1, sample2;
  logic [15:0]       word1_q, word2_q;

  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  // Frame launches in the LAUNCH cycle itself so the words
  // change exactly when spi_start is seen.
  assign fire      = (state == LAUNCH) && !spi_busy;
  assign spi_start = fire;
  assign ready     = (state == WAIT_TICK);
  assign spi_word1 = fire ? make_frame(sample1) : word1_q;
  assign spi_word2 = fire ? make_frame(sample2) : word2_q;

  // Next-state logic; mid-frame states ignore enable.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (enable) state_nx = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable)   state_nx = IDLE;
        else if (tick) state_nx = FETCH1;
      end
      FETCH1: state_nx = CAP1;
      CAP1:   state_nx = CAP2;
      CAP2:   state_nx = LAUNCH;
      LAUNCH: begin
        if (!spi_busy) state_nx = WAIT_SPI;
      end
      WAIT_SPI: begin
        if (!spi_first && !spi_busy)
          state_nx = enable ? WAIT_TICK : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register plus first-cycle flag for WAIT_SPI.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      spi_first <= 1'b0;
    end else begin
      state     <= state_nx;
      spi_first <= fire;
    end
  end

  // LUT addressing, accumulators, sample capture and held frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc1     <= '0;
      acc2     <= '0;
      sample1  <= '0;
      sample2  <= '0;
      bank     <= 1'b0;
      lut_addr <= '0;
      word1_q  <= '0;
      word2_q  <= '0;
    end else begin
      if (state == WAIT_TICK && enable && tick) begin
        bank     <= sel_wave;
        lut_addr <= {sel_wave, acc1[ACC_W-1 -: LUT_AW]};
      end
      if (state == FETCH1) begin
        lut_addr <= {bank, acc2[ACC_W-1 -: LUT_AW]};
        acc1     <= acc1 + phase_inc1;
        acc2     <= acc2 + phase_inc2;
      end
      if (state == CAP1) sample1 <= lut_data;
      if (state == CAP2) sample2 <= lut_data;
      if (fire) begin
        word1_q <= make_frame(sample1);
        word2_q <= make_frame(sample2);
      end
    end
  end

  // Sticky overrun: a tick outside WAIT_TICK is dropped.
  always_ff @(posedge clk) begin
    if (rst || !enable)
      overrun <= 1'b0;
    else if (tick && state != WAIT_TICK)
      overrun <= 1'b1;
  end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler with SAMPLE_DIV=20.
// LUT model returns {bank, addr, 3'b0} one cycle after the address.
module tb_dac_sample_scheduler;

  localparam int SD = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        sel_wave = 1'b0;
  logic [15:0] phase_inc1 = '0;
  logic [15:0] phase_inc2 = '0;
  logic [8:0]  lut_addr;
  logic [11:0] lut_data = '0;
  logic        spi_start;
  logic [15:0] spi_word1, spi_word2;
  logic        spi_busy;
  logic        ready, overrun;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_starts = 0;
  int busy_len = 3;
  logic [7:0] busy_cnt = '0;

  dac_sample_scheduler #(
    .SAMPLE_DIV(SD),
    .ACC_W(16),
    .LUT_AW(8),
    .DATA_W(12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sel_wave   (sel_wave),
    .phase_inc1 (phase_inc1),
    .phase_inc2 (phase_inc2),
    .lut_addr   (lut_addr),
    .lut_data   (lut_data),
    .spi_start  (spi_start),
    .spi_word1  (spi_word1),
    .spi_word2  (spi_word2),
    .spi_busy   (spi_busy),
    .ready      (ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) lut_data <= {lut_addr, 3'b000};

  always @(posedge clk) if (spi_start) n_starts <= n_starts + 1;

  always @(posedge clk) begin
    if (rst)
      busy_cnt <= '0;
    else if (spi_start)
      busy_cnt <= busy_len[7:0];
    else if (busy_cnt != 0)
      busy_cnt <= busy_cnt - 1'b1;
  end
  assign spi_busy = (busy_cnt != 0);

  typedef struct {
    bit          do_rst;
    logic [15:0] inc1;
    logic [15:0] inc2;
    bit          sel;
    logic [15:0] w1;
    logic [15:0] w2;
    int          gap;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_start(output int c);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (spi_start) break;
    end
    c = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, lut_addr, 0);
    chk({tag, "_start"}, spi_start, 0);
    chk({tag, "_w1"}, spi_word1, 0);
    chk({tag, "_w2"}, spi_word2, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    int t0, c, ns;

    tbl[0] = '{1, 16'h0100, 16'h0200, 0, 16'h0000, 16'h0000, 24};
    tbl[1] = '{0, 16'h0100, 16'h0200, 0, 16'h0008, 16'h0010, 20};
    tbl[2] = '{0, 16'h1000, 16'h0010, 1, 16'h0810, 16'h0820, 20};
    tbl[3] = '{0, 16'h0001, 16'h8000, 0, 16'h0090, 16'h0020, 20};
    tbl[4] = '{0, 16'h0001, 16'h8000, 1, 16'h0890, 16'h0C20, 20};
    tbl[5] = '{0, 16'h0000, 16'h0000, 0, 16'h0090, 16'h0020, 20};
    tbl[6] = '{1, 16'hFF00, 16'h0000, 0, 16'h0000, 16'h0000, 24};
    tbl[7] = '{0, 16'hFF00, 16'h0000, 0, 16'h07F8, 16'h0000, 20};
    tbl[8] = '{0, 16'hFF00, 16'h0000, 0, 16'h07F0, 16'h0000, 20};

    repeat (3) @(negedge clk);
    chk_zero("reset");

    rst = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("ready_armed", ready, 1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_idle", ready, 0);

    t0 = cyc;
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].do_rst) do_reset();
      phase_inc1 = tbl[i].inc1;
      phase_inc2 = tbl[i].inc2;
      sel_wave   = tbl[i].sel;
      if (tbl[i].do_rst) begin
        enable = 1'b1;
        t0 = cyc;
      end
      wait_start(c);
      chk($sformatf("row%0d_w1", i), spi_word1, tbl[i].w1);
      chk($sformatf("row%0d_w2", i), spi_word2, tbl[i].w2);
      chk($sformatf("row%0d_gap", i), c - t0, tbl[i].gap);
      t0 = c;
    end

    // bank change mid-frame only affects the next frame
    repeat (17) @(negedge clk);
    sel_wave = 1'b1;
    wait_start(c);
    chk("bank_old_w1", spi_word1[11], 0);
    chk("bank_old_w2", spi_word2[11], 0);
    wait_start(c);
    chk("bank_new_w1", spi_word1[11], 1);
    chk("bank_new_w2", spi_word2[11], 1);

    // long busy: one tick missed, overrun sticks
    t0 = c;
    chk("ovr_before", overrun, 0);
    busy_len = 30;
    repeat (20) @(negedge clk);
    chk("ovr_set", overrun, 1);
    wait_start(c);
    chk("ovr_gap", c - t0, 40);
    chk("ovr_sticky", overrun, 1);
    busy_len = 3;
    enable = 1'b0;
    @(negedge clk);
    chk("ovr_clear", overrun, 0);
    repeat (10) @(negedge clk);

    // reset in CAP1
    sel_wave = 1'b0;
    enable = 1'b1;
    repeat (22) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_cap1");
    rst = 1'b0;
    t0 = cyc;
    wait_start(c);
    chk("rst_gap", c - t0, 24);
    chk("rst_w1", spi_word1, 0);

    // enable drops during LAUNCH
    repeat (19) @(negedge clk);
    @(posedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    chk("drop_start", spi_start, 1);
    chk("drop_w1", spi_word1, 16'h07F8);
    @(negedge clk);
    ns = n_starts;
    chk("drop_ready0", ready, 0);
    repeat (40) @(negedge clk);
    chk("drop_nostart", n_starts, ns);
    chk("drop_ready1", ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
